imm_ext_pipe: RTL and testbench

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

---
 rtl/imm_ext_pipe.sv | 112 +++++++++++
 tb/tb_imm_ext_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe.sv
// Immediate extender feeding a 2-entry output FIFO with registered handshakes.
// Optional completed-transfer counter enabled by macro IMM_EXT_PIPE_CNT_EN.
module imm_ext_pipe #(
    parameter int unsigned bus_size    = 32,
    parameter int unsigned bus_size_in = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [bus_size_in-1:0] in,
    input  logic [1:0]             mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [bus_size-1:0]    out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            xfer_cnt
);

    localparam int unsigned EXT_W = bus_size - bus_size_in;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [bus_size-1:0] tail;
    logic [bus_size-1:0] head_next;
    logic [bus_size-1:0] tail_next;
    logic [bus_size-1:0] sext;
    logic [bus_size-1:0] ext;
    logic                push;
    logic                pop;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Extension of the raw immediate; only captured on acceptance
    always_comb begin
        sext = {{EXT_W{in[bus_size_in-1]}}, in};
        ext  = '0;
        case (mode)
            2'b00:   ext = {{EXT_W{1'b0}}, in};
            2'b01:   ext = sext;
            2'b10:   ext = {in, {EXT_W{1'b0}}};
            default: ext = sext << 2;
        endcase
    end

    // Occupancy FSM; out is the FIFO head register, tail the second slot
    always_comb begin
        state_next = state;
        head_next  = out;
        tail_next  = tail;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_next = ONE;
                    head_next  = ext;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_next = ext;
                end else if (push) begin
                    tail_next  = ext;
                    state_next = FULL;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_next  = tail;
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            out       <= '0;
            tail      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            out       <= head_next;
            tail      <= tail_next;
            in_ready  <= (state_next != FULL);
            out_valid <= (state_next != EMPTY);
        end
    end

`ifdef IMM_EXT_PIPE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (pop) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`else
    assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: directed scenarios plus random traffic against a queue model.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] xfer_cnt;

    logic [3:0]  s_in;
    logic [1:0]  s_mode;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_out;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [15:0] s_xfer_cnt;

    int          n_pass = 0;
    int          n_chk  = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    imm_ext_pipe dut (
        .clk(clk), .rst(rst), .in(in), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .out_valid(out_valid),
        .out_ready(out_ready), .xfer_cnt(xfer_cnt)
    );

    imm_ext_pipe #(.bus_size(8), .bus_size_in(4)) dut_s (
        .clk(clk), .rst(rst), .in(s_in), .mode(s_mode), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .out(s_out), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .xfer_cnt(s_xfer_cnt)
    );

    // Arithmetic view of the extension rules, independent of bit slicing
    function automatic logic [31:0] ref_ext(int bs, int bsi, longint x, int m);
        longint sv;
        longint v;
        sv = (x >= (longint'(1) << (bsi - 1))) ? x - (longint'(1) << bsi) : x;
        case (m)
            0:       v = x;
            1:       v = sv;
            2:       v = x * (longint'(1) << (bs - bsi));
            default: v = sv * 4;
        endcase
        return 32'(v & ((longint'(1) << bs) - 1));
    endfunction

    function automatic logic [15:0] exp_xfer();
`ifdef IMM_EXT_PIPE_CNT_EN
        return exp_cnt;
`else
        return 16'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock; outputs sampled 1 time unit after the edge
    task automatic tick();
        logic p;
        p = out_valid && out_ready && !rst;
        @(posedge clk);
        #1;
        if (rst) exp_cnt = 16'd0;
        else if (p) exp_cnt = exp_cnt + 16'd1;
    endtask

    logic [31:0] mexp[4];
    logic [7:0]  sexp[3];
    logic [3:0]  svals[3];

    initial begin
        mexp  = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004};
        svals = '{4'b1001, 4'b1101, 4'b0101};
        sexp  = '{8'hF9, 8'hFD, 8'h05};
        rst = 1'b1; in = '0; mode = '0; in_valid = 1'b0; out_ready = 1'b1;
        s_in = '0; s_mode = 2'b01; s_in_valid = 1'b0; s_out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out", out, 32'd0);
        chk("reset_xfer", 32'(xfer_cnt), 32'(exp_xfer()));

        // Extension modes on consecutive cycles
        in = 16'h8001;
        in_valid = 1'b1;
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            tick();
            chk($sformatf("mode%0d_out", m), out, mexp[m]);
            chk($sformatf("mode%0d_ref", m), out, ref_ext(32, 16, 64'h8001, m));
            chk($sformatf("mode%0d_valid", m), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("modes_drain_valid", 32'(out_valid), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        in_valid = 1'b1; in = 16'h0005; mode = 2'b01;
        tick();
        chk("bp_ready_one", 32'(in_ready), 32'd1);
        in = 16'hFFFF; mode = 2'b00;
        tick();
        chk("bp_ready_full", 32'(in_ready), 32'd0);
        chk("bp_head", out, 32'h00000005);
        in = 16'h1234; mode = 2'b01;
        tick();
        chk("bp_ignored_ready", 32'(in_ready), 32'd0);
        chk("bp_ignored_head", out, 32'h00000005);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_second", out, 32'h0000FFFF);
        chk("bp_second_valid", 32'(out_valid), 32'd1);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Streaming push and pop together
        mode = 2'b00;
        in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in = 16'(i);
            tick();
            chk($sformatf("stream%0d_out", i), out, 32'(i));
            chk($sformatf("stream%0d_ready", i), 32'(in_ready), 32'd1);
            chk($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_xfer", 32'(xfer_cnt), 32'(exp_xfer()));

        // Reset while full
        out_ready = 1'b0;
        in_valid = 1'b1; in = 16'h00AA;
        tick();
        tick();
        chk("rstmid_full", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_valid", 32'(out_valid), 32'd0);
        chk("rstmid_ready", 32'(in_ready), 32'd1);
        chk("rstmid_out", out, 32'd0);
        chk("rstmid_xfer", 32'(xfer_cnt), 32'd0);
        in_valid = 1'b1; in = 16'h7FFF; mode = 2'b01;
        tick();
        chk("rstmid_push", out, 32'h00007FFF);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();

`ifdef IMM_EXT_PIPE_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b1; mode = 2'b00;
        for (int i = 0; i < 5; i++) begin
            in = 16'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("cnt_five", 32'(xfer_cnt), 32'd5);
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        force dut.xfer_cnt = 16'hFFFF;
        #1;
        release dut.xfer_cnt;
        exp_cnt = 16'hFFFF;
        out_ready = 1'b1;
        tick();
        chk("cnt_wrap", 32'(xfer_cnt), 32'd0);
`endif

        // Narrow instance, sign extension
        s_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_in = svals[i];
            tick();
            chk($sformatf("narrow%0d", i), 32'(s_out), 32'(sexp[i]));
            chk($sformatf("narrow%0d_ref", i), 32'(s_out), ref_ext(8, 4, longint'(svals[i]), 1));
            chk($sformatf("narrow%0d_ready", i), 32'(s_in_ready), 32'd1);
        end
        s_in_valid = 1'b0;
        tick();

        // Random traffic against the queue model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            logic acc;
            logic pp;
            logic [31:0] r;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in        = 16'($urandom);
            mode      = 2'($urandom);
            chk("rnd_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("rnd_valid", 32'(out_valid), 32'(q.size() > 0));
            if (q.size() > 0) chk("rnd_out", out, q[0]);
            acc = in_valid && (q.size() < 2);
            pp  = out_ready && (q.size() > 0);
            r   = ref_ext(32, 16, longint'(in), int'(mode));
            tick();
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(r);
        end
        chk("rnd_xfer", 32'(xfer_cnt), 32'(exp_xfer()));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
